// File: rtl/kd_pkg.sv
// Shared types and default widths for the KD-tree leaf fetch stage.
package kd_pkg;

    localparam int DEF_ADDRESS_WIDTH = 8;
    localparam int DEF_LEAF_WIDTH    = 55;
    localparam int DEF_QID_WIDTH     = 12;

    typedef enum logic {
        LANE0 = 1'b0,
        LANE1 = 1'b1
    } lane_e;

    typedef struct packed {
        logic [DEF_ADDRESS_WIDTH-1:0] index;
        logic [DEF_QID_WIDTH-1:0]     qid;
    } leaf_req_t;

    typedef struct packed {
        logic [DEF_LEAF_WIDTH-1:0] patch;
        lane_e                     lane;
        logic [DEF_QID_WIDTH-1:0]  qid;
    } leaf_beat_t;

    function automatic lane_e other_lane(input lane_e l);
        other_lane = (l == LANE0) ? LANE1 : LANE0;
    endfunction

endpackage

// File: rtl/kd_sync_fifo.sv
// Synchronous FIFO, power-of-two depth. Head entry is visible on rd_data while
// not empty; storage is cleared on reset so the head reads zero afterwards.
module kd_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             wr_fire_s;
    logic             rd_fire_s;

    assign full      = (count_q == (AW+1)'(DEPTH));
    assign empty     = (count_q == '0);
    assign wr_fire_s = wr_en && !full;
    assign rd_fire_s = rd_en && !empty;
    assign rd_data   = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (wr_fire_s) begin
                mem_q[wr_ptr_q] <= wr_data;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (rd_fire_s) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + (AW+1)'(wr_fire_s) - (AW+1)'(rd_fire_s);
        end
    end

endmodule

// File: rtl/kd_leaf_fetch.sv
// Two-lane leaf-index buffer, round-robin leaf SRAM fetch and tagged output stream.
// Optional statistics counters are enabled by defining KD_LEAF_FETCH_STATS_EN.
module kd_leaf_fetch
    import kd_pkg::*;
#(
    parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
    parameter int LEAF_WIDTH    = DEF_LEAF_WIDTH,
    parameter int FIFO_DEPTH    = 8,
    parameter int QID_WIDTH     = DEF_QID_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     frame_start,
    input  logic                     receiver_en,
    input  logic [ADDRESS_WIDTH-1:0] leaf_index,
    input  logic                     receiver_two_en,
    input  logic [ADDRESS_WIDTH-1:0] leaf_index_two,
    output logic                     mem_ren,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    input  logic [LEAF_WIDTH-1:0]    mem_rdata,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LEAF_WIDTH-1:0]    out_patch,
    output logic                     out_lane,
    output logic [QID_WIDTH-1:0]     out_qid,
    output logic                     overflow
`ifdef KD_LEAF_FETCH_STATS_EN
    ,
    output logic [15:0]              drop_count,
    output logic [15:0]              served_count_0,
    output logic [15:0]              served_count_1
`endif
);

    typedef struct packed {
        logic [ADDRESS_WIDTH-1:0] index;
        logic [QID_WIDTH-1:0]     qid;
    } req_t;

    typedef struct packed {
        logic [LEAF_WIDTH-1:0] patch;
        logic                  lane;
        logic [QID_WIDTH-1:0]  qid;
    } beat_t;

    logic [1:0]               strobe_s;
    logic [1:0]               avail_s;
    logic [1:0]               fifo_wr_s;
    logic [1:0]               fifo_rd_s;
    logic [1:0]               fifo_full_s;
    logic [1:0]               fifo_empty_s;
    logic [1:0]               drop_s;
    req_t                     fifo_wdata_s [2];
    req_t                     fifo_rdata_s [2];
    req_t                     issue_req_s;
    lane_e                    gnt_s;
    logic                     issue_s;
    logic                     bypass_s;
    logic                     drain_s;
    logic [2:0]               buf_count_s;
    logic [2:0]               occ_s;
    logic                     out_full_s;
    logic                     out_empty_s;
    beat_t                    ret_beat_s;
    beat_t                    out_head_s;

    logic [QID_WIDTH-1:0]     qid_q [2];
    lane_e                    rr_q;
    logic                     mem_ren_q;
    logic [ADDRESS_WIDTH-1:0] mem_addr_q;
    logic                     pend_lane_q;
    logic [QID_WIDTH-1:0]     pend_qid_q;
    logic                     ret_valid_q;
    logic                     ret_lane_q;
    logic [QID_WIDTH-1:0]     ret_qid_q;
    logic                     overflow_q;

    for (genvar l = 0; l < 2; l++) begin : g_lane
        kd_sync_fifo #(
            .DEPTH (FIFO_DEPTH),
            .WIDTH ($bits(req_t))
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (fifo_wr_s[l]),
            .wr_data (fifo_wdata_s[l]),
            .rd_en   (fifo_rd_s[l]),
            .rd_data (fifo_rdata_s[l]),
            .full    (fifo_full_s[l]),
            .empty   (fifo_empty_s[l])
        );
    end

    kd_sync_fifo #(
        .DEPTH (2),
        .WIDTH ($bits(beat_t))
    ) u_out_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (ret_valid_q),
        .wr_data (ret_beat_s),
        .rd_en   (out_ready),
        .rd_data (out_head_s),
        .full    (out_full_s),
        .empty   (out_empty_s)
    );

    // Occupancy counts buffered beats plus both read stages, so the 2-entry
    // buffer always has room when a read returns. An empty lane with a live
    // strobe issues straight from the input to keep mem_ren registered.
    always_comb begin
        strobe_s              = {receiver_two_en, receiver_en};
        fifo_wdata_s[0].index = leaf_index;
        fifo_wdata_s[0].qid   = frame_start ? '0 : qid_q[0];
        fifo_wdata_s[1].index = leaf_index_two;
        fifo_wdata_s[1].qid   = frame_start ? '0 : qid_q[1];
        avail_s               = strobe_s | ~fifo_empty_s;
        buf_count_s           = out_full_s ? 3'd2 : (out_empty_s ? 3'd0 : 3'd1);
        occ_s                 = buf_count_s + {2'b00, mem_ren_q} + {2'b00, ret_valid_q};
        drain_s               = !out_empty_s && out_ready;
        issue_s               = (|avail_s) && (occ_s < (3'd2 + {2'b00, drain_s}));
        if (&avail_s) begin
            gnt_s = rr_q;
        end else if (avail_s[1]) begin
            gnt_s = LANE1;
        end else begin
            gnt_s = LANE0;
        end
        bypass_s    = issue_s && fifo_empty_s[gnt_s];
        issue_req_s = bypass_s ? fifo_wdata_s[gnt_s] : fifo_rdata_s[gnt_s];
        fifo_rd_s   = 2'b00;
        fifo_wr_s   = strobe_s;
        if (bypass_s) begin
            fifo_wr_s[gnt_s] = 1'b0;
        end else if (issue_s) begin
            fifo_rd_s[gnt_s] = 1'b1;
        end else begin
            fifo_rd_s = 2'b00;
        end
        drop_s           = fifo_wr_s & fifo_full_s;
        ret_beat_s.patch = mem_rdata;
        ret_beat_s.lane  = ret_lane_q;
        ret_beat_s.qid   = ret_qid_q;
    end

    // Issue/return pipeline, arbitration pointer, query-ID counters and loss flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_ren_q   <= 1'b0;
            mem_addr_q  <= '0;
            pend_lane_q <= 1'b0;
            pend_qid_q  <= '0;
            ret_valid_q <= 1'b0;
            ret_lane_q  <= 1'b0;
            ret_qid_q   <= '0;
            rr_q        <= LANE0;
            overflow_q  <= 1'b0;
            qid_q[0]    <= '0;
            qid_q[1]    <= '0;
        end else begin
            mem_ren_q <= issue_s;
            if (issue_s) begin
                mem_addr_q  <= issue_req_s.index;
                pend_lane_q <= gnt_s;
                pend_qid_q  <= issue_req_s.qid;
                rr_q        <= other_lane(gnt_s);
            end
            ret_valid_q <= mem_ren_q;
            ret_lane_q  <= pend_lane_q;
            ret_qid_q   <= pend_qid_q;
            if (|drop_s) begin
                overflow_q <= 1'b1;
            end
            for (int l = 0; l < 2; l++) begin
                if (frame_start) begin
                    qid_q[l] <= strobe_s[l] ? QID_WIDTH'(1) : '0;
                end else if (strobe_s[l]) begin
                    qid_q[l] <= qid_q[l] + 1'b1;
                end
            end
        end
    end

    assign mem_ren   = mem_ren_q;
    assign mem_addr  = mem_addr_q;
    assign overflow  = overflow_q;
    assign out_valid = !out_empty_s;
    assign out_patch = out_head_s.patch;
    assign out_lane  = out_head_s.lane;
    assign out_qid   = out_head_s.qid;

`ifdef KD_LEAF_FETCH_STATS_EN
    logic [15:0] drop_cnt_q;
    logic [15:0] served0_q;
    logic [15:0] served1_q;
    logic [16:0] drop_sum_s;

    assign drop_sum_s = {1'b0, drop_cnt_q} + {16'h0000, drop_s[0]} + {16'h0000, drop_s[1]};

    // Saturating drop counter and wrapping per-lane retire counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q <= 16'h0000;
            served0_q  <= 16'h0000;
            served1_q  <= 16'h0000;
        end else begin
            drop_cnt_q <= drop_sum_s[16] ? 16'hFFFF : drop_sum_s[15:0];
            if (drain_s && out_head_s.lane) begin
                served1_q <= served1_q + 16'h0001;
            end else if (drain_s) begin
                served0_q <= served0_q + 16'h0001;
            end
        end
    end

    assign drop_count     = drop_cnt_q;
    assign served_count_0 = served0_q;
    assign served_count_1 = served1_q;
`endif

endmodule

// File: tb/tb_kd_leaf_fetch.sv
// Directed self-checking bench for kd_leaf_fetch with a 1-cycle SRAM model.
module tb_kd_leaf_fetch;
    import kd_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_start = 1'b0;
    logic        receiver_en = 1'b0;
    logic [7:0]  leaf_index = 8'h00;
    logic        receiver_two_en = 1'b0;
    logic [7:0]  leaf_index_two = 8'h00;
    logic        mem_ren;
    logic [7:0]  mem_addr;
    logic [54:0] mem_rdata = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [54:0] out_patch;
    logic        out_lane;
    logic [11:0] out_qid;
    logic        overflow;
`ifdef KD_LEAF_FETCH_STATS_EN
    logic [15:0] drop_count;
    logic [15:0] served_count_0;
    logic [15:0] served_count_1;
`endif

    int checks = 0;
    int errors = 0;
    int ren_cnt = 0;
    leaf_beat_t beat_q [$];

    kd_leaf_fetch dut (
        .clk             (clk),
        .rst             (rst),
        .frame_start     (frame_start),
        .receiver_en     (receiver_en),
        .leaf_index      (leaf_index),
        .receiver_two_en (receiver_two_en),
        .leaf_index_two  (leaf_index_two),
        .mem_ren         (mem_ren),
        .mem_addr        (mem_addr),
        .mem_rdata       (mem_rdata),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_patch       (out_patch),
        .out_lane        (out_lane),
        .out_qid         (out_qid),
        .overflow        (overflow)
`ifdef KD_LEAF_FETCH_STATS_EN
        ,
        .drop_count      (drop_count),
        .served_count_0  (served_count_0),
        .served_count_1  (served_count_1)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [54:0] patch_of(input logic [7:0] a);
        patch_of = {~a, 39'h12_3456_789A, a};
    endfunction

    // Leaf SRAM: data for the address presented with mem_ren appears next cycle.
    always @(posedge clk) begin
        if (mem_ren) mem_rdata <= patch_of(mem_addr);
    end

    // Monitor: read strobes and retired beats, sampled mid-cycle.
    always begin
        @(negedge clk);
        #2;
        if (mem_ren) ren_cnt++;
        if (out_valid && out_ready) beat_q.push_back('{patch: out_patch, lane: lane_e'(out_lane), qid: out_qid});
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        receiver_en = 1'b0;
        receiver_two_en = 1'b0;
        frame_start = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_beats(input int base, input int n);
        for (int k = 0; k < 200 && beat_q.size() < base + n; k++) tick();
        check("beat_count", 64'(beat_q.size() - base), 64'(n));
    endtask

    task automatic check_beat(input string tag, input int pos, input logic lane, input logic [11:0] qid, input logic [7:0] idx);
        if (pos < beat_q.size()) begin
            check({tag, "_lane"}, 64'(beat_q[pos].lane), 64'(lane));
            check({tag, "_qid"}, 64'(beat_q[pos].qid), 64'(qid));
            check({tag, "_patch"}, 64'(beat_q[pos].patch), 64'(patch_of(idx)));
        end else begin
            check({tag, "_missing"}, 64'(beat_q.size()), 64'(pos + 1));
        end
    endtask

    initial begin
        int base;
        int ren_base;
        logic [11:0] fs_qid [8];
        fs_qid = '{12'd0, 12'd1, 12'd2, 12'd3, 12'd4, 12'd5, 12'd0, 12'd1};

        // Reset values
        tick();
        tick();
        check("rst_mem_ren", 64'(mem_ren), 64'h0);
        check("rst_mem_addr", 64'(mem_addr), 64'h0);
        check("rst_out_valid", 64'(out_valid), 64'h0);
        check("rst_out_patch", 64'(out_patch), 64'h0);
        check("rst_out_lane", 64'(out_lane), 64'h0);
        check("rst_out_qid", 64'(out_qid), 64'h0);
        check("rst_overflow", 64'(overflow), 64'h0);
        rst = 1'b0;
        tick();

        // Single lane-0 strobe: latency t+1 read, t+3 beat
        receiver_en = 1'b1;
        leaf_index = 8'h2A;
        tick();
        receiver_en = 1'b0;
        check("lat_mem_ren", 64'(mem_ren), 64'h1);
        check("lat_mem_addr", 64'(mem_addr), 64'h2A);
        tick();
        check("lat_ren_low", 64'(mem_ren), 64'h0);
        check("lat_addr_hold", 64'(mem_addr), 64'h2A);
        check("lat_valid_early", 64'(out_valid), 64'h0);
        tick();
        check("lat_valid", 64'(out_valid), 64'h1);
        check("lat_lane", 64'(out_lane), 64'h0);
        check("lat_qid", 64'(out_qid), 64'h0);
        check("lat_patch", 64'(out_patch), 64'(patch_of(8'h2A)));
        tick();
        check("lat_retired", 64'(out_valid), 64'h0);

        // Both lanes every cycle for 4 cycles
        do_reset();
        base = beat_q.size();
        for (int i = 0; i < 4; i++) begin
            receiver_en = 1'b1;
            leaf_index = 8'(8'h80 + i);
            receiver_two_en = 1'b1;
            leaf_index_two = 8'(8'hC0 + i);
            tick();
        end
        receiver_en = 1'b0;
        receiver_two_en = 1'b0;
        wait_beats(base, 8);
        for (int k = 0; k < 8; k++) begin
            check_beat($sformatf("dual%0d", k), base + k, 1'(k % 2), 12'(k / 2),
                       (k % 2 == 1) ? 8'(8'hC0 + k / 2) : 8'(8'h80 + k / 2));
        end
        check("dual_overflow", 64'(overflow), 64'h0);

        // Stalled consumer, 11 lane-0 strobes into an 8-deep FIFO
        do_reset();
        out_ready = 1'b0;
        base = beat_q.size();
        ren_base = ren_cnt;
        for (int i = 0; i < 11; i++) begin
            receiver_en = 1'b1;
            leaf_index = 8'(8'h40 + i);
            tick();
            if (i == 9) check("ovf_before_11th", 64'(overflow), 64'h0);
        end
        receiver_en = 1'b0;
        check("ovf_set", 64'(overflow), 64'h1);
        for (int i = 0; i < 9; i++) tick();
        check("ovf_reads_issued", 64'(ren_cnt - ren_base), 64'd2);
        check("ovf_stalled_valid", 64'(out_valid), 64'h1);
        check("ovf_no_retire", 64'(beat_q.size() - base), 64'd0);
        out_ready = 1'b1;
        wait_beats(base, 10);
        for (int i = 0; i < 5; i++) tick();
        check("ovf_no_extra", 64'(beat_q.size() - base), 64'd10);
        for (int k = 0; k < 10; k++) begin
            check_beat($sformatf("ovf%0d", k), base + k, 1'b0, 12'(k), 8'(8'h40 + k));
        end
        check("ovf_sticky", 64'(overflow), 64'h1);
`ifdef KD_LEAF_FETCH_STATS_EN
        check("stat_drop", 64'(drop_count), 64'd1);
        check("stat_served0", 64'(served_count_0), 64'd10);
        check("stat_served1", 64'(served_count_1), 64'd0);
`endif

        // frame_start with a lane-1 strobe after qid 5
        do_reset();
        check("ovf_cleared", 64'(overflow), 64'h0);
        base = beat_q.size();
        for (int i = 0; i < 8; i++) begin
            receiver_two_en = 1'b1;
            leaf_index_two = 8'(8'h10 + i);
            frame_start = (i == 6);
            tick();
        end
        receiver_two_en = 1'b0;
        frame_start = 1'b0;
        wait_beats(base, 8);
        for (int k = 0; k < 8; k++) begin
            check_beat($sformatf("fs%0d", k), base + k, 1'b1, fs_qid[k], 8'(8'h10 + k));
        end

        // Reset one cycle after mem_ren discards the in-flight read
        do_reset();
        tick();
        receiver_en = 1'b1;
        leaf_index = 8'h33;
        tick();
        receiver_en = 1'b0;
        check("mid_mem_ren", 64'(mem_ren), 64'h1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_valid", 64'(out_valid), 64'h0);
        check("mid_mem_ren0", 64'(mem_ren), 64'h0);
        check("mid_mem_addr", 64'(mem_addr), 64'h0);
        check("mid_patch", 64'(out_patch), 64'h0);
        check("mid_lane", 64'(out_lane), 64'h0);
        check("mid_qid", 64'(out_qid), 64'h0);
        base = beat_q.size();
        for (int i = 0; i < 5; i++) tick();
        check("mid_no_beat", 64'(beat_q.size() - base), 64'd0);
        check("mid_valid_later", 64'(out_valid), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/kd_leaf_fetch.md
# kd_leaf_fetch

Downstream stage of the internal-node KD tree. Takes the two per-cycle leaf-index results (lane 0 / lane 1) with their `receiver_en` strobes. Buffers each lane in a small FIFO, round-robin arbitrates the lanes onto the single-port leaf-patch SRAM, and presents fetched leaf patches with lane and query-ID tags on a valid/ready stream to the distance-compute stage. The tree cannot stall, so the block absorbs bursts and flags loss.

## Interface
Parameters
- `ADDRESS_WIDTH`, 8: leaf index / leaf SRAM address width
- `LEAF_WIDTH`, 55: leaf patch data width
- `FIFO_DEPTH`, 8: entries per lane FIFO, power of two ≥ 2
- `QID_WIDTH`, 12: per-lane query-ID counter width

Ports
- `clk` in 1: single clock
- `rst` in 1: synchronous, active-high reset
- `frame_start` in 1: clears both query-ID counters
- `receiver_en` in 1: lane-0 leaf index valid (single-cycle strobe, no backpressure)
- `leaf_index` in ADDRESS_WIDTH: lane-0 leaf index
- `receiver_two_en` in 1: lane-1 valid
- `leaf_index_two` in ADDRESS_WIDTH: lane-1 leaf index
- `mem_ren` out 1: leaf SRAM read strobe, active high
- `mem_addr` out ADDRESS_WIDTH: leaf SRAM address
- `mem_rdata` in LEAF_WIDTH: SRAM data, valid exactly 1 cycle after `mem_ren`
- `out_valid` out 1: output beat valid
- `out_ready` in 1: consumer ready
- `out_patch` out LEAF_WIDTH: fetched leaf patch
- `out_lane` out 1: 0 = lane 0, 1 = lane 1
- `out_qid` out QID_WIDTH: query ID of the beat
- `overflow` out 1: sticky; set when an enqueue hits a full FIFO; cleared only by `rst`

## Operation
- Enqueue: a strobe high at cycle t writes {index, lane qid} into that lane's FIFO at the end of t. The lane qid then increments, wrapping at 2^QID_WIDTH. Both lanes may enqueue in the same cycle.
- `frame_start`: both qid counters go to 0. A same-cycle enqueue is stored with qid 0 and the counter becomes 1. FIFO contents and in-flight reads are untouched.
- Full FIFO on strobe: entry dropped, qid still increments (downstream sees a gap), `overflow` set.
- Credits: the output buffer has 2 entries. `credit = 2 − (outstanding read + buffered beats)`.
- Issue: when credit > 0 and at least one FIFO is non-empty, pop one entry. Drive `mem_ren=1`, `mem_addr=index`, and record lane/qid in a 1-deep pending register.
- Arbitration:
  - Only one lane non-empty: that lane is granted.
  - Both non-empty: round-robin pointer decides. The pointer moves to the other lane after each grant. After reset the pointer favours lane 0.
- Return: the cycle after issue, `mem_rdata` plus the pending tag is written into the output buffer (FIFO order).
- Output: the head beat is shown while `out_valid=1`; it retires when `out_valid && out_ready`. Outputs are stable while `out_valid && !out_ready`.
- Simultaneous return and drain into a full buffer: legal, since credit accounting guarantees a slot.

## Timing
- Reset values:
  - `mem_ren`, `out_valid`, `overflow` = 0.
  - `mem_addr`, `out_patch`, `out_lane`, `out_qid` = 0.
  - FIFOs empty, qids 0, RR pointer lane 0, pending cleared.
  - Reset mid-read discards the returning data.
- Latency with `out_ready=1` and empty pipeline:
  - strobe at t → `mem_ren` at t+1 → `out_valid` at t+3 (data registered at end of t+2).
- Throughput: one beat per cycle total with `out_ready` held high. Both lanes strobing every cycle therefore fills the FIFOs at net +1 entry/cycle.
- `mem_ren` is a registered output. `mem_addr` is held at its last value when `mem_ren=0`.

## Configuration
- `KD_LEAF_FETCH_STATS_EN` defined: adds outputs `drop_count` (16 bits, saturating count of dropped enqueues) and `served_count_0` / `served_count_1` (16 bits each, wrapping count of retired beats per lane). All cleared by `rst`.
- Not defined: these ports and counters are absent. `overflow` is always present.

## Structure
- Shared package `kd_pkg`:
  - default widths (ADDRESS_WIDTH, LEAF_WIDTH, QID_WIDTH)
  - lane enum `LANE0`/`LANE1`
  - struct `leaf_req_t` {index, qid}
  - struct `leaf_beat_t` {patch, lane, qid}
- Sub-module `kd_sync_fifo`: parameterised depth/width synchronous FIFO with `full`/`empty`. Instantiated twice for the lane FIFOs; the 2-entry output buffer may reuse it.

## Test plan
- Single lane-0 strobe, index 0x2A, SRAM model returns 0x2A-tagged data → `mem_ren` at t+1 with addr 0x2A; `out_valid` at t+3 with lane 0, qid 0.
- Both lanes strobe every cycle for 4 cycles with `out_ready=1` → 8 beats, alternating lane 0,1,0,1…; qids 0–3 per lane in order; no overflow.
- `out_ready=0` for 20 cycles while lane 0 strobes 11 times, FIFO_DEPTH=8:
  - only 2 reads issue;
  - the 11th strobe drops;
  - `overflow`=1;
  - after release, beats carry qids 0–9, and qid 10 is missing.
- `frame_start` coincident with a lane-1 strobe after qid 5 → that beat has qid 0, the next has qid 1.
- Assert `rst` one cycle after `mem_ren` → no `out_valid` for the in-flight read; all outputs 0 next cycle.
- With `KD_LEAF_FETCH_STATS_EN`, replay the overflow scenario → `drop_count`=1, `served_count_0`=10.
